led_afterglow: RTL and testbench
================================

LED_AFTERGLOW -- requirements
Module: led_afterglow

Interface
REQ-001 Parameter DECAY_TICKS, default 32'd400_000, clk cycles between brightness-decay steps (legal range 1..2^32-1).
REQ-002 Parameter DECAY_STEP, default 8'd8, amount subtracted from each channel level per decay step (legal range 1..255).
REQ-003 clk  input  1  single clock for all logic.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 en  input  1  output enable; low blanks outputs and clears state.
REQ-006 pattern_in  input  3  LED pattern from the upstream pattern generator; bit i high lights channel i.
REQ-007 gain  input  8  global brightness scale; 255 is full.
REQ-008 led_out  output  3  PWM drive to the LEDs, registered.
REQ-009 all_dark  output  1  registered; high when all three channel levels are 0.

Function
REQ-010 pattern_in shall be registered once into pattern_q; all level logic shall use pattern_q only.
REQ-011 decay_cnt (32 bit) shall count 0..DECAY_TICKS-1 and wrap to 0.
REQ-012 decay_tick shall be asserted for exactly the one cycle in which decay_cnt == DECAY_TICKS-1.
REQ-013 With DECAY_TICKS=1, decay_tick shall be high every cycle.
REQ-014 pwm_cnt (8 bit) shall increment every cycle and wrap 255 -> 0, giving a PWM period of 256 cycles.
REQ-015 Per channel i, level[i] (8 bit) shall load 255 on the edge after pattern_q[i] is high, regardless of decay_tick (load has priority).
REQ-016 Else, on decay_tick, level[i] shall become level[i]-DECAY_STEP, saturating at 0 with no wrap below 0.
REQ-017 Else, level[i] shall hold.
REQ-018 duty[i] shall be (level[i] * (gain+1)) >> 8, computed combinationally; a 16-bit product is sufficient and the result lies in 0..255.
REQ-019 led_out[i] shall be registered as (pwm_cnt < duty[i]).
REQ-020 duty 0 shall give a constant-low led_out; duty 255 shall give led_out high 255 of every 256 cycles.
REQ-021 Latency: pattern_in sampled high at edge k -> level 255 at edge k+1 -> led_out reflects the new level at edge k+2.
REQ-022 all_dark shall be registered from (level[0]|level[1]|level[2]) == 0, one cycle after the levels.
REQ-023 en low shall, on each edge, clear all levels, pwm_cnt and decay_cnt to 0, force led_out to 0 and set all_dark to 1.
REQ-024 pattern_q shall still track pattern_in while en is low.
REQ-025 On the first edge with en high, counting shall resume from 0 and levels shall load per REQ-015.
REQ-026 Several channels may load or decay in the same cycle, independently.
REQ-027 A bit of pattern_in held high shall keep its level at 255 with no decay.
REQ-028 A pattern_in value of 0 is legal and shall simply let all channels decay.

Reset
REQ-029 While rst is high, asynchronously: pattern_q=0, levels=0, pwm_cnt=0, decay_cnt=0, led_out=0, all_dark=1.
REQ-030 After rst deasserts, the first active edge shall behave as a normal operating cycle.
REQ-031 rst asserted mid-decay or mid-PWM period shall discard all state immediately, without waiting for a clock edge.

Verification
REQ-032 DECAY_TICKS=4, DECAY_STEP=64, gain=255, en=1; pattern_in=001 for 1 cycle then 000 -> level[0] follows 255, 191, 127, 63, 0 at 4-cycle steps, then holds 0; all_dark rises 1 cycle after level[0] reaches 0.
REQ-033 gain=255, level=128 held (pattern bit pulsed, DECAY_TICKS large) -> led_out[0] high for 128 of 256 cycles; gain=127 -> duty 64, high 64 of 256 cycles.
REQ-034 DECAY_STEP=200, level 255 -> 55 -> 0 (saturates), never wraps to 111.
REQ-035 pattern_in sequence 001,010,100,010 (each held 8 cycles, DECAY_TICKS=2, DECAY_STEP=32) -> the trailing channels fade while the active channel stays at 255; levels checked each cycle against a model.
REQ-036 Assert rst asynchronously between clock edges while levels are nonzero -> led_out=0 and all_dark=1 immediately; drop rst and drive pattern_in=100 -> led_out[2] toggles starting 2 edges after sampling.
REQ-037 Drop en for 3 cycles mid-fade -> led_out=0 and levels=0 during that time; restore en -> pwm_cnt restarts at 0.

Source files
------------

// File: rtl/led_afterglow.sv
// Three-channel LED afterglow: a lit pattern bit snaps its channel to full brightness,
// which then fades in DECAY_STEP decrements and is rendered as gain-scaled 256-cycle PWM.
module led_afterglow #(
  parameter logic [31:0] DECAY_TICKS = 32'd400_000,
  parameter logic [7:0]  DECAY_STEP  = 8'd8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [2:0] pattern_in,
  input  logic [7:0] gain,
  output logic [2:0] led_out,
  output logic       all_dark
);

  localparam int unsigned NCH    = 3;
  localparam int unsigned LVL_W  = 8;
  localparam int unsigned PWM_W  = 8;
  localparam int unsigned CNT_W  = 32;
  localparam int unsigned PROD_W = 16;

  localparam logic [CNT_W-1:0] TICK_LAST = DECAY_TICKS - 32'd1;
  localparam logic [LVL_W-1:0] LVL_FULL  = 8'hFF;

  logic [NCH-1:0]                pattern_q;
  logic [CNT_W-1:0]              decay_cnt_q, decay_cnt_d;
  logic                          decay_tick;
  logic [PWM_W-1:0]              pwm_cnt_q, pwm_cnt_d;
  logic [NCH-1:0][LVL_W-1:0]     level_q, level_d;
  logic [PROD_W-1:0]             gain_p1;
  logic [NCH-1:0][PROD_W-1:0]    prod;
  logic [NCH-1:0][LVL_W-1:0]     duty;
  logic [NCH-1:0]                led_out_q, led_out_d;
  logic                          all_dark_q, all_dark_d;

  // Decay timebase and PWM ramp; both restart from zero whenever the block is disabled.
  always_comb begin
    decay_tick  = (decay_cnt_q == TICK_LAST);
    decay_cnt_d = decay_tick ? '0 : decay_cnt_q + 32'd1;
    pwm_cnt_d   = pwm_cnt_q + 8'd1;
    if (!en) begin
      decay_cnt_d = '0;
      pwm_cnt_d   = '0;
    end
  end

  // Per-channel level: disable clears, pattern reload beats decay, decay saturates at 0.
  always_comb begin
    level_d = level_q;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (!en) begin
        level_d[i] = '0;
      end else if (pattern_q[i]) begin
        level_d[i] = LVL_FULL;
      end else if (decay_tick) begin
        level_d[i] = (level_q[i] > DECAY_STEP) ? level_q[i] - DECAY_STEP : '0;
      end
    end
  end

  // gain+1 makes 255 an exact unity scale; the top byte of the product is the duty.
  always_comb begin
    gain_p1 = {8'd0, gain} + 16'd1;
    for (int unsigned i = 0; i < NCH; i++) begin
      prod[i] = {8'd0, level_q[i]} * gain_p1;
      duty[i] = prod[i][PROD_W-1:LVL_W];
    end
  end

  always_comb begin
    led_out_d  = '0;
    all_dark_d = 1'b1;
    if (en) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        led_out_d[i] = (pwm_cnt_q < duty[i]);
      end
      all_dark_d = ((level_q[0] | level_q[1] | level_q[2]) == 8'd0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pattern_q   <= '0;
      decay_cnt_q <= '0;
      pwm_cnt_q   <= '0;
      level_q     <= '0;
      led_out_q   <= '0;
      all_dark_q  <= 1'b1;
    end else begin
      pattern_q   <= pattern_in;
      decay_cnt_q <= decay_cnt_d;
      pwm_cnt_q   <= pwm_cnt_d;
      level_q     <= level_d;
      led_out_q   <= led_out_d;
      all_dark_q  <= all_dark_d;
    end
  end

  assign led_out  = led_out_q;
  assign all_dark = all_dark_q;

endmodule

// File: tb/tb_led_afterglow.sv
// Directed bench for led_afterglow: four instances with different decay parameters share
// the stimulus; each section observes only the instance whose parameters it exercises.
module tb_led_afterglow;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [2:0] pat;
  logic [7:0] gain;
  logic [2:0] led_a, led_b, led_c, led_d;
  logic       dark_a, dark_b, dark_c, dark_d;

  int n_pass = 0;
  int n_chk  = 0;

  always #5 clk = ~clk;

  led_afterglow #(.DECAY_TICKS(32'd4),   .DECAY_STEP(8'd64))  dut_a (
    .clk(clk), .rst(rst), .en(en), .pattern_in(pat), .gain(gain), .led_out(led_a), .all_dark(dark_a));
  led_afterglow #(.DECAY_TICKS(32'd600), .DECAY_STEP(8'd127)) dut_b (
    .clk(clk), .rst(rst), .en(en), .pattern_in(pat), .gain(gain), .led_out(led_b), .all_dark(dark_b));
  led_afterglow #(.DECAY_TICKS(32'd1),   .DECAY_STEP(8'd200)) dut_c (
    .clk(clk), .rst(rst), .en(en), .pattern_in(pat), .gain(gain), .led_out(led_c), .all_dark(dark_c));
  led_afterglow #(.DECAY_TICKS(32'd2),   .DECAY_STEP(8'd32))  dut_d (
    .clk(clk), .rst(rst), .en(en), .pattern_in(pat), .gain(gain), .led_out(led_d), .all_dark(dark_d));

  // Hand-computed level[0] of dut_a after edges 1..20 following a one-cycle 001 pulse.
  logic [7:0] exp_fade [20] = '{8'd0, 8'd255, 8'd255, 8'd191, 8'd191, 8'd191, 8'd191,
                                8'd127, 8'd127, 8'd127, 8'd127, 8'd63, 8'd63, 8'd63, 8'd63,
                                8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
  logic [7:0] exp_sat  [5]  = '{8'd0, 8'd255, 8'd55, 8'd0, 8'd0};
  logic [2:0] patseq   [5]  = '{3'b001, 3'b010, 3'b100, 3'b010, 3'b000};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    int cnt0;
    int cnt1;
    logic [7:0] m_lvl [3];
    logic [2:0] m_pq;
    logic [7:0] nl;

    rst  = 1'b1;
    en   = 1'b1;
    pat  = 3'b000;
    gain = 8'd255;
    #2;
    chk("rst_led",     32'(led_a), 32'd0);
    chk("rst_dark",    32'(dark_a), 32'd1);
    chk("rst_pat_q",   32'(dut_a.pattern_q), 32'd0);
    chk("rst_pwm",     32'(dut_a.pwm_cnt_q), 32'd0);
    chk("rst_decay",   dut_a.decay_cnt_q, 32'd0);
    chk("rst_level",   32'(dut_a.level_q), 32'd0);
    chk("rst_dark_bcd", 32'({dark_b, dark_c, dark_d}), 32'd7);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Fade of one pulsed channel, 4-cycle ticks, step 64.
    do_reset();
    pat = 3'b001;
    for (int n = 1; n <= 20; n++) begin
      step();
      pat = 3'b000;
      chk($sformatf("fade_lvl_e%0d", n), 32'(dut_a.level_q[0]), 32'(exp_fade[n-1]));
      chk($sformatf("fade_dark_e%0d", n), 32'(dark_a), (n <= 2 || n >= 17) ? 32'd1 : 32'd0);
    end

    // Large step saturates at 0; DECAY_TICKS=1 ticks every cycle.
    do_reset();
    pat = 3'b001;
    for (int n = 1; n <= 5; n++) begin
      step();
      pat = 3'b000;
      chk($sformatf("sat_lvl_e%0d", n), 32'(dut_c.level_q[0]), 32'(exp_sat[n-1]));
      chk($sformatf("sat_cnt_e%0d", n), dut_c.decay_cnt_q, 32'd0);
    end
    chk("sat_dark", 32'(dark_c), 32'd1);

    // PWM duty: level 128 after one decay of 127, then gain 255 / 127 / 0.
    do_reset();
    gain = 8'd255;
    pat  = 3'b001;
    step();
    pat = 3'b000;
    for (int n = 2; n <= 599; n++) step();
    chk("pwm_lvl_e599", 32'(dut_b.level_q[0]), 32'd255);
    step();
    chk("pwm_lvl_e600", 32'(dut_b.level_q[0]), 32'd128);
    cnt0 = 0;
    cnt1 = 0;
    for (int k = 0; k < 256; k++) begin
      step();
      cnt0 += int'(led_b[0]);
      cnt1 += int'(led_b[1]);
    end
    chk("pwm_g255_high", 32'(cnt0), 32'd128);
    chk("pwm_duty0_high", 32'(cnt1), 32'd0);
    gain = 8'd127;
    cnt0 = 0;
    for (int k = 0; k < 256; k++) begin
      step();
      cnt0 += int'(led_b[0]);
    end
    chk("pwm_g127_high", 32'(cnt0), 32'd64);
    chk("pwm_lvl_hold", 32'(dut_b.level_q[0]), 32'd128);
    gain = 8'd0;
    cnt0 = 0;
    for (int k = 0; k < 256; k++) begin
      step();
      cnt0 += int'(led_b[0]);
    end
    chk("pwm_g0_high", 32'(cnt0), 32'd0);
    gain = 8'd255;

    // Rotating pattern against a per-edge model (ticks on even edges after reset).
    do_reset();
    m_pq = 3'b000;
    for (int i = 0; i < 3; i++) m_lvl[i] = 8'd0;
    for (int n = 1; n <= 40; n++) begin
      pat = patseq[(n-1)/8];
      step();
      for (int i = 0; i < 3; i++) begin
        if (m_pq[i]) nl = 8'd255;
        else if (n % 2 == 0) nl = (m_lvl[i] > 8'd32) ? m_lvl[i] - 8'd32 : 8'd0;
        else nl = m_lvl[i];
        m_lvl[i] = nl;
      end
      m_pq = pat;
      for (int i = 0; i < 3; i++)
        chk($sformatf("rot_e%0d_ch%0d", n, i), 32'(dut_d.level_q[i]), 32'(m_lvl[i]));
    end

    // Asynchronous reset between edges, then a held pattern on channel 2.
    do_reset();
    pat = 3'b111;
    step();
    step();
    step();
    chk("arst_pre_led", 32'(led_a), 32'd7);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_led", 32'(led_a), 32'd0);
    chk("arst_dark", 32'(dark_a), 32'd1);
    chk("arst_level", 32'(dut_a.level_q), 32'd0);
    #1;
    rst = 1'b0;
    pat = 3'b100;
    step();
    chk("arst_e1_led", 32'(led_a), 32'd0);
    chk("arst_e1_lvl", 32'(dut_a.level_q[2]), 32'd0);
    step();
    chk("arst_e2_led", 32'(led_a), 32'd0);
    chk("arst_e2_lvl", 32'(dut_a.level_q[2]), 32'd255);
    for (int n = 3; n <= 10; n++) begin
      step();
      chk($sformatf("hold_e%0d_led", n), 32'(led_a), 32'd4);
      chk($sformatf("hold_e%0d_lvl", n), 32'(dut_a.level_q[2]), 32'd255);
    end

    // Enable dropped for three cycles mid-fade.
    do_reset();
    pat = 3'b111;
    step();
    pat = 3'b000;
    step();
    chk("en_e2_lvl", 32'(dut_a.level_q), 32'hFFFFFF);
    step();
    chk("en_e3_led", 32'(led_a), 32'd7);
    step();
    chk("en_e4_lvl", 32'(dut_a.level_q), 32'hBFBFBF);
    step();
    chk("en_e5_led", 32'(led_a), 32'd7);
    en = 1'b0;
    for (int n = 6; n <= 8; n++) begin
      if (n == 8) pat = 3'b010;
      step();
      chk($sformatf("dis_e%0d_led", n), 32'(led_a), 32'd0);
      chk($sformatf("dis_e%0d_lvl", n), 32'(dut_a.level_q), 32'd0);
      chk($sformatf("dis_e%0d_dark", n), 32'(dark_a), 32'd1);
      chk($sformatf("dis_e%0d_pwm", n), 32'(dut_a.pwm_cnt_q), 32'd0);
      chk($sformatf("dis_e%0d_dcnt", n), dut_a.decay_cnt_q, 32'd0);
    end
    chk("dis_pat_track", 32'(dut_a.pattern_q), 32'd2);
    en = 1'b1;
    step();
    chk("ren_pwm", 32'(dut_a.pwm_cnt_q), 32'd1);
    chk("ren_dcnt", dut_a.decay_cnt_q, 32'd1);
    chk("ren_lvl", 32'(dut_a.level_q), 32'h00FF00);
    chk("ren_dark", 32'(dark_a), 32'd1);
    step();
    chk("ren_led", 32'(led_a), 32'd2);
    chk("ren_dark2", 32'(dark_a), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
